// File: rtl/aes_io_pkg.sv
// Shared definitions for the AES byte-serial input/output path.
// The collector and the 128-to-8 serializer use the same state encoding and block geometry.
package aes_io_pkg;

   localparam int BYTE_W      = 8;
   localparam int BLOCK_BYTES = 16;

   typedef enum logic [3:0] {
      IDLE  = 4'd0,
      TRANS = 4'd1,
      OVER  = 4'd2
   } io_state_t;

endpackage

// File: rtl/sipo_8to128.sv
// Serial-in/parallel-out byte collector: gathers 16 bytes into one 128-bit AES block.
// Byte k lands in out[8k+7:8k]; the full block is held with valid=1 until clear.
module sipo_8to128
   import aes_io_pkg::*;
#(
   parameter int in_N  = BYTE_W,
   parameter int set_N = BLOCK_BYTES,
   parameter int out_N = in_N * set_N
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   input  logic [in_N-1:0]  in,
   input  logic             clear,
   output logic             ready,
   output logic             valid,
   output logic [4:0]       set_num,
   output logic [out_N-1:0] out
);

   io_state_t       state_r;
   logic [4:0]      cnt_r;
   logic            state_ok_s;
   logic            accept_s;
   logic            wipe_s;
   logic [in_N-1:0] lane_r [set_N];

   assign ready   = (state_r != OVER);
   assign valid   = (state_r == OVER);
   assign set_num = cnt_r;

   // Bytes are only taken while collecting; clear always wins over a same-cycle byte.
   always_comb begin
      state_ok_s = 1'b0;
      accept_s   = 1'b0;
      wipe_s     = 1'b0;
      if ((state_r == IDLE) || (state_r == TRANS) || (state_r == OVER)) begin
         state_ok_s = 1'b1;
      end else begin
         state_ok_s = 1'b0;
      end
      if (in_valid && !clear && ((state_r == IDLE) || (state_r == TRANS))) begin
         accept_s = 1'b1;
      end else begin
         accept_s = 1'b0;
      end
      if (clear || !state_ok_s) begin
         wipe_s = 1'b1;
      end else begin
         wipe_s = 1'b0;
      end
   end

   // Collector state and byte count.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r <= IDLE;
         cnt_r   <= 5'd0;
      end else if (clear) begin
         state_r <= IDLE;
         cnt_r   <= 5'd0;
      end else begin
         case (state_r)
            IDLE: begin
               if (in_valid) begin
                  state_r <= TRANS;
                  cnt_r   <= 5'd1;
               end else begin
                  cnt_r   <= 5'd0;
               end
            end
            TRANS: begin
               if (in_valid) begin
                  cnt_r <= cnt_r + 5'd1;
                  if (cnt_r == 5'(set_N - 1)) begin
                     state_r <= OVER;
                  end
               end
            end
            OVER: begin
               state_r <= OVER;
            end
            default: begin
               state_r <= IDLE;
               cnt_r   <= 5'd0;
            end
         endcase
      end
   end

   // One register per byte lane; the lane enable is a decode of the byte count.
   for (genvar k = 0; k < set_N; k++) begin : g_lane
      logic lane_we_s;
      assign lane_we_s = accept_s && (cnt_r[3:0] == 4'(k));

      // Lane storage, zeroed whenever the collector returns to IDLE.
      always_ff @(posedge clk or negedge reset) begin
         if (!reset) begin
            lane_r[k] <= '0;
         end else if (wipe_s) begin
            lane_r[k] <= '0;
         end else if (lane_we_s) begin
            lane_r[k] <= in;
         end
      end

      assign out[in_N*k +: in_N] = lane_r[k];
   end

endmodule

// File: doc/sipo_8to128.md
# sipo_8to128

Serial-in/parallel-out byte collector on the AES input path. It accepts a stream of 16 bytes under a valid/ready handshake and assembles them into one 128-bit block for the AES core. It holds the block with `valid` asserted until `clear` is pulsed. It is the input-side counterpart of the 128-to-8 output serializer and uses the same byte order: byte k sits at bits [8k+7:8k], and byte 0 is the first transferred.

## Interface
Parameters:
- `in_N`, 8: input byte width.
- `set_N`, 16: bytes per block.
- `out_N`, 128: output block width; must equal `in_N*set_N`.

Ports:
- `clk`, input, 1: single clock; all logic on rising edge.
- `reset`, input, 1: asynchronous, active-low reset.
- `in_valid`, input, 1: `in` carries a byte this cycle.
- `in`, input, `in_N`: input byte.
- `clear`, input, 1: release the held block or abort a partial block; return to IDLE.
- `ready`, output, 1: block can accept a byte this cycle.
- `valid`, output, 1: `out` holds a complete 16-byte block.
- `set_num`, output, 5: bytes captured so far, 0..16.
- `out`, output, `out_N`: assembled block.

## Operation
- States:
  - IDLE: `cnt`=0, nothing captured.
  - COLLECT: 1..15 bytes captured.
  - FULL: 16 bytes captured.
  - Encoding: IDLE=0, COLLECT=1, FULL=2, stored in a 4-bit state register.
- A transfer occurs on a rising edge where `in_valid && ready`. The byte is written to `out[8*cnt+7 -: 8]` and `cnt` increments by 1.
- `cnt` is 5 bits wide. It never exceeds 16 and never wraps.
- `ready` = (state != FULL). It is combinational from state only, with no dependence on `in_valid`.
- `valid` = (state == FULL). `set_num` = `cnt`.
- Transitions:
  - IDLE → COLLECT on a transfer.
  - COLLECT → FULL on the transfer that captures byte 15, i.e. `cnt` was 15.
  - COLLECT → COLLECT on other transfers or idle cycles.
  - FULL → IDLE on `clear`.
  - Any state → IDLE on `clear`.
  - Unused encodings → IDLE.
- `clear` has priority over `in_valid` in every state. A byte presented in the same cycle as `clear` is discarded. On `clear`, `cnt` and `out` go to 0.
- In FULL, `in_valid` is ignored. `out`, `cnt`=16 and `valid`=1 are held indefinitely until `clear`.
- `in_valid` gaps in COLLECT are allowed. `cnt` and `out` are held across gaps; there is no timeout.
- Bytes not yet written in a partial block read as 0, because `out` is zeroed on IDLE entry.

## Timing
- Reset (`reset`=0), asynchronous:
  - state=IDLE, `cnt`=0, `out`=0.
  - `valid`=0, `ready`=1, `set_num`=0.
- Capture latency is 1 cycle: a byte appears in `out` and in `set_num` after the accepting edge.
- Block latency: `valid` rises in the cycle after the edge that accepts the 16th byte. The minimum is 16 cycles from the first accepted byte to `valid`=1 with back-to-back input.
- In that same cycle `ready` falls. This means `in_valid` held high on the cycle after the 16th byte does not transfer.
- `clear` in FULL: `valid` falls and `ready` rises on the next cycle. The earliest next-block byte is accepted one cycle after the `clear` edge.
- Reset asserted mid-block or in FULL discards everything immediately. Outputs take their reset values without waiting for a clock.
- `out` is registered. `ready`, `valid` and `set_num` are decoded from registers, so there is no combinational path from inputs to outputs.

## Structure
- Shared package `aes_io_pkg` holds:
  - the state encodings IDLE/TRANS(COLLECT)/OVER(FULL), used by both the serializer and this block;
  - `BYTE_W`=8 and `BLOCK_BYTES`=16.
- Single module with no sub-module. The byte-lane write enable is a 4-to-16 decode of `cnt[3:0]` inlined as a generate loop over 16 lanes.

## Test plan
- Reset, then 16 back-to-back bytes 0x00..0x0F:
  - `valid`=1 exactly 16 cycles after the first byte;
  - `out`=128'h0F0E0D0C0B0A09080706050403020100;
  - `set_num`=16, `ready`=0.
- Same 16 bytes with `in_valid` low on every other cycle:
  - identical `out`;
  - `valid` after the 31st cycle;
  - `set_num` increments only on high cycles.
- FULL state with `in_valid`=1 and `in`=0xAA held for 10 cycles, then `clear`:
  - `out` unchanged during hold;
  - next cycle `valid`=0, `out`=0, `set_num`=0, `ready`=1.
- 5 bytes 0x11..0x15, then `clear` together with `in_valid`/0x16:
  - IDLE, `set_num`=0, `out`=0;
  - next block starts cleanly at lane 0.
- `reset` pulsed low asynchronously between clock edges after 9 bytes:
  - outputs go to reset values immediately;
  - 16 new bytes then assemble correctly.
- Loopback: drive `out`/`valid` into the 128-to-8 serializer:
  - serializer emits the same 16 bytes in input order.
